// File: rtl/mystic_main_mem_rx_ctrl.sv
// UART boot loader: receives 8N1 bytes and writes them to consecutive main-memory addresses,
// holding the core off during an upload. Optional stop-bit check: define MYSTIC_RX_FRAME_CHECK_EN.
module mystic_main_mem_rx_ctrl #(
    parameter int IDLE_BITS = 32,
    parameter int ADDR_W    = 18
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              rx_i,
    input  logic [15:0]       baud_div,
    output logic              disable_core_n,
    output logic [7:0]        uart_mem_dout,
    output logic [ADDR_W-1:0] uart_mem_addr,
    output logic              uart_mem_we
);
    localparam int IB_W = $clog2(IDLE_BITS + 1);
    localparam logic [IB_W-1:0] IDLE_LAST = IB_W'(IDLE_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WRITE} state_t;
    state_t state, state_nxt;

    logic            rx_s1, rx;
    logic [15:0]     baud_q, tick, idle_tick;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic [IB_W-1:0] idle_bits;
    logic            half_hit, bit_hit, idle_hit, start_det, timeout, frame_wait, stop_ok;

    // Very small dividers would leave no room for mid-bit sampling.
    function automatic logic [15:0] clamp_baud(input logic [15:0] d);
        return (d < 16'd4) ? 16'd4 : d;
    endfunction

    assign half_hit  = (tick == {1'b0, baud_q[15:1]});
    assign bit_hit   = (tick == baud_q - 16'd1);
    assign idle_hit  = (idle_tick == baud_q - 16'd1);
    assign start_det = (state == S_IDLE) && !rx && !frame_wait;
    assign timeout   = (state == S_IDLE) && !disable_core_n && idle_hit && (idle_bits == IDLE_LAST);

`ifdef MYSTIC_RX_FRAME_CHECK_EN
    assign stop_ok = rx;

    // After a framing error the line must go idle before a new start is trusted.
    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            frame_wait <= 1'b0;
        else if (state == S_STOP && bit_hit && !rx)
            frame_wait <= 1'b1;
        else if (state == S_IDLE && rx)
            frame_wait <= 1'b0;
    end
`else
    assign stop_ok    = 1'b1;
    assign frame_wait = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        uart_mem_we = 1'b0;
        case (state)
            S_IDLE:  if (start_det) state_nxt = S_START;
            S_START: if (half_hit) state_nxt = rx ? S_IDLE : S_DATA;
            S_DATA:  if (bit_hit && bit_idx == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (bit_hit) state_nxt = stop_ok ? S_WRITE : S_IDLE;
            S_WRITE: begin
                uart_mem_we = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rx_s1          <= 1'b1;
            rx             <= 1'b1;
            baud_q         <= '0;
            tick           <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            idle_tick      <= '0;
            idle_bits      <= '0;
            disable_core_n <= 1'b1;
            uart_mem_dout  <= '0;
            uart_mem_addr  <= '0;
        end else begin
            rx_s1 <= rx_i;
            rx    <= rx_s1;
            case (state)
                S_IDLE: begin
                    if (start_det) begin
                        tick   <= '0;
                        baud_q <= clamp_baud(baud_div);
                    end
                    // Timeout takes priority over a simultaneous start bit.
                    if (timeout) begin
                        disable_core_n <= 1'b1;
                        uart_mem_addr  <= '0;
                        idle_tick      <= '0;
                        idle_bits      <= '0;
                    end else if (start_det) begin
                        idle_tick <= '0;
                        idle_bits <= '0;
                    end else if (!disable_core_n) begin
                        if (idle_hit) begin
                            idle_tick <= '0;
                            idle_bits <= idle_bits + IB_W'(1);
                        end else begin
                            idle_tick <= idle_tick + 16'd1;
                        end
                    end
                end
                S_START: begin
                    if (half_hit) begin
                        tick    <= '0;
                        bit_idx <= '0;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_hit) begin
                        tick    <= '0;
                        shift   <= {rx, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_hit) begin
                        tick <= '0;
                        if (stop_ok) begin
                            uart_mem_dout  <= shift;
                            disable_core_n <= 1'b0;
                        end
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_WRITE: uart_mem_addr <= uart_mem_addr + ADDR_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mystic_main_mem_rx_ctrl.sv
// Directed bench for mystic_main_mem_rx_ctrl: a behavioural UART transmitter drives rx_i and a
// negedge monitor records every write strobe for the per-scenario tasks to compare.
module tb_mystic_main_mem_rx_ctrl;
    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rstn_i = 1'b0;
    logic              rx_i = 1'b1;
    logic [15:0]       baud_div = 16'd868;
    logic              disable_core_n;
    logic [7:0]        uart_mem_dout;
    logic [ADDR_W-1:0] uart_mem_addr;
    logic              uart_mem_we;

    mystic_main_mem_rx_ctrl #(.IDLE_BITS(32), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .rx_i(rx_i), .baud_div(baud_div),
        .disable_core_n(disable_core_n), .uart_mem_dout(uart_mem_dout),
        .uart_mem_addr(uart_mem_addr), .uart_mem_we(uart_mem_we)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     exp_addr = 0;
    longint cyc = 0;

    logic [7:0]        mon_dout[$];
    logic [ADDR_W-1:0] mon_addr[$];
    logic              mon_dis[$];
    longint            mon_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (uart_mem_we === 1'b1) begin
            mon_dout.push_back(uart_mem_dout);
            mon_addr.push_back(uart_mem_addr);
            mon_dis.push_back(disable_core_n);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int bd, input logic stop_bit, output longint t0);
        @(negedge clk);
        rx_i = 1'b0;
        t0 = cyc;
        repeat (bd) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (bd) @(negedge clk);
        end
        rx_i = stop_bit;
        repeat (bd) @(negedge clk);
        rx_i = 1'b1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; rx_i = 1'b1; baud_div = 16'd868;
        repeat (5) @(negedge clk);
        checks++; if (disable_core_n !== 1'b1) begin errors++; $display("FAIL rst_dis: got %b expected 1", disable_core_n); end
        checks++; if (uart_mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", uart_mem_we); end
        checks++; if (uart_mem_addr !== '0) begin errors++; $display("FAIL rst_addr: got %0h expected 0", uart_mem_addr); end
        checks++; if (uart_mem_dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %0h expected 0", uart_mem_dout); end
        rstn_i = 1'b1;
        repeat (2000) @(negedge clk);
        checks++; if (mon_dout.size() != 0) begin errors++; $display("FAIL idle_we_count: got %0d expected 0", mon_dout.size()); end
        checks++; if (disable_core_n !== 1'b1) begin errors++; $display("FAIL idle_dis: got %b expected 1", disable_core_n); end
        checks++; if (uart_mem_addr !== '0) begin errors++; $display("FAIL idle_addr: got %0h expected 0", uart_mem_addr); end
        checks++; if (uart_mem_dout !== 8'h00) begin errors++; $display("FAIL idle_dout: got %0h expected 0", uart_mem_dout); end
    endtask

    task automatic test_glitch();
        int n0 = mon_dout.size();
        baud_div = 16'd868;
        @(negedge clk); rx_i = 1'b0;
        repeat (200) @(negedge clk);
        rx_i = 1'b1;
        repeat (1500) @(negedge clk);
        checks++; if (mon_dout.size() != n0) begin errors++; $display("FAIL glitch_we: got %0d writes expected %0d", mon_dout.size(), n0); end
        checks++; if (disable_core_n !== 1'b1) begin errors++; $display("FAIL glitch_dis: got %b expected 1", disable_core_n); end
        checks++; if (uart_mem_addr !== '0) begin errors++; $display("FAIL glitch_addr: got %0h expected 0", uart_mem_addr); end
    endtask

    task automatic test_single_byte();
        int n0 = mon_dout.size();
        longint t0, lat;
        baud_div = 16'd868;
        send_byte(8'hAB, 868, 1'b1, t0);
        repeat (5) @(negedge clk);
        checks++;
        if (mon_dout.size() != n0 + 1) begin
            errors++; $display("FAIL single_we_count: got %0d expected %0d", mon_dout.size(), n0 + 1);
        end else begin
            lat = mon_cyc[n0] - t0;
            checks++; if (mon_dout[n0] !== 8'hAB) begin errors++; $display("FAIL single_dout: got %0h expected ab", mon_dout[n0]); end
            checks++; if (mon_addr[n0] !== '0) begin errors++; $display("FAIL single_addr: got %0h expected 0", mon_addr[n0]); end
            checks++; if (mon_dis[n0] !== 1'b0) begin errors++; $display("FAIL single_dis_at_we: got %b expected 0", mon_dis[n0]); end
            checks++; if (lat < 9 * 868 || lat > 10 * 868) begin errors++; $display("FAIL single_latency: got %0d expected 7812..8680", lat); end
        end
        checks++; if (uart_mem_addr !== 18'd1) begin errors++; $display("FAIL single_addr_after: got %0h expected 1", uart_mem_addr); end
        checks++; if (disable_core_n !== 1'b0) begin errors++; $display("FAIL single_dis_after: got %b expected 0", disable_core_n); end
    endtask

    task automatic test_mid_reset();
        int n0;
        logic [7:0] b = 8'h5C;
        baud_div = 16'd32;
        @(negedge clk); rx_i = 1'b0;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_i = b[i];
            repeat (32) @(negedge clk);
        end
        rx_i = b[4];
        repeat (16) @(negedge clk);
        rstn_i = 1'b0;
        @(negedge clk);
        checks++; if (disable_core_n !== 1'b1) begin errors++; $display("FAIL midrst_dis: got %b expected 1", disable_core_n); end
        checks++; if (uart_mem_addr !== '0) begin errors++; $display("FAIL midrst_addr: got %0h expected 0", uart_mem_addr); end
        checks++; if (uart_mem_dout !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %0h expected 0", uart_mem_dout); end
        checks++; if (uart_mem_we !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b expected 0", uart_mem_we); end
        n0 = mon_dout.size();
        rstn_i = 1'b1; rx_i = 1'b1;
        repeat (20 * 32) @(negedge clk);
        checks++; if (mon_dout.size() != n0) begin errors++; $display("FAIL midrst_no_we: got %0d writes expected %0d", mon_dout.size(), n0); end
        exp_addr = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[25];
        int n0 = mon_dout.size();
        longint t0;
        bytes[0] = 8'hAB; bytes[1] = 8'hCD; bytes[2] = 8'h12; bytes[3] = 8'h34;
        for (int i = 4; i < 25; i++) bytes[i] = 8'($urandom_range(0, 255));
        baud_div = 16'd32;
        for (int i = 0; i < 25; i++) begin
            send_byte(bytes[i], 32, 1'b1, t0);
            checks++; if (disable_core_n !== 1'b0) begin errors++; $display("FAIL b2b_gap_dis[%0d]: got %b expected 0", i, disable_core_n); end
        end
        checks++;
        if (mon_dout.size() != n0 + 25) begin
            errors++; $display("FAIL b2b_we_count: got %0d expected %0d", mon_dout.size() - n0, 25);
        end else begin
            for (int i = 0; i < 25; i++) begin
                checks++; if (mon_dout[n0+i] !== bytes[i]) begin errors++; $display("FAIL b2b_dout[%0d]: got %0h expected %0h", i, mon_dout[n0+i], bytes[i]); end
                checks++; if (mon_addr[n0+i] !== ADDR_W'(i)) begin errors++; $display("FAIL b2b_addr[%0d]: got %0h expected %0h", i, mon_addr[n0+i], i); end
                checks++; if (mon_dis[n0+i] !== 1'b0) begin errors++; $display("FAIL b2b_dis[%0d]: got %b expected 0", i, mon_dis[n0+i]); end
            end
        end
        exp_addr = 25;
    endtask

    task automatic test_timeout();
        int n0;
        longint t0;
        repeat (31 * 32) @(negedge clk);
        checks++; if (disable_core_n !== 1'b0) begin errors++; $display("FAIL timeout_early_dis: got %b expected 0", disable_core_n); end
        checks++; if (uart_mem_addr !== ADDR_W'(exp_addr)) begin errors++; $display("FAIL timeout_early_addr: got %0h expected %0h", uart_mem_addr, exp_addr); end
        repeat (2 * 32) @(negedge clk);
        checks++; if (disable_core_n !== 1'b1) begin errors++; $display("FAIL timeout_dis: got %b expected 1", disable_core_n); end
        checks++; if (uart_mem_addr !== '0) begin errors++; $display("FAIL timeout_addr: got %0h expected 0", uart_mem_addr); end
        n0 = mon_dout.size();
        send_byte(8'h5A, 32, 1'b1, t0);
        repeat (3) @(negedge clk);
        checks++;
        if (mon_dout.size() != n0 + 1) begin
            errors++; $display("FAIL reopen_we_count: got %0d expected %0d", mon_dout.size(), n0 + 1);
        end else begin
            checks++; if (mon_dout[n0] !== 8'h5A) begin errors++; $display("FAIL reopen_dout: got %0h expected 5a", mon_dout[n0]); end
            checks++; if (mon_addr[n0] !== '0) begin errors++; $display("FAIL reopen_addr: got %0h expected 0", mon_addr[n0]); end
            checks++; if (mon_dis[n0] !== 1'b0) begin errors++; $display("FAIL reopen_dis: got %b expected 0", mon_dis[n0]); end
        end
        exp_addr = 1;
    endtask

    task automatic test_frame();
        int n0;
        longint t0;
        repeat (64) @(negedge clk);
        n0 = mon_dout.size();
        send_byte(8'h3C, 32, 1'b0, t0);
        repeat (96) @(negedge clk);
`ifdef MYSTIC_RX_FRAME_CHECK_EN
        checks++; if (mon_dout.size() != n0) begin errors++; $display("FAIL frame_drop_we: got %0d writes expected %0d", mon_dout.size(), n0); end
        checks++; if (uart_mem_addr !== ADDR_W'(exp_addr)) begin errors++; $display("FAIL frame_drop_addr: got %0h expected %0h", uart_mem_addr, exp_addr); end
`else
        checks++;
        if (mon_dout.size() != n0 + 1) begin
            errors++; $display("FAIL frame_keep_we: got %0d writes expected %0d", mon_dout.size(), n0 + 1);
        end else begin
            checks++; if (mon_dout[n0] !== 8'h3C) begin errors++; $display("FAIL frame_keep_dout: got %0h expected 3c", mon_dout[n0]); end
            checks++; if (mon_addr[n0] !== ADDR_W'(exp_addr)) begin errors++; $display("FAIL frame_keep_addr: got %0h expected %0h", mon_addr[n0], exp_addr); end
        end
        exp_addr++;
`endif
        n0 = mon_dout.size();
        send_byte(8'h77, 32, 1'b1, t0);
        repeat (3) @(negedge clk);
        checks++;
        if (mon_dout.size() != n0 + 1) begin
            errors++; $display("FAIL after_frame_we: got %0d writes expected %0d", mon_dout.size(), n0 + 1);
        end else begin
            checks++; if (mon_dout[n0] !== 8'h77) begin errors++; $display("FAIL after_frame_dout: got %0h expected 77", mon_dout[n0]); end
            checks++; if (mon_addr[n0] !== ADDR_W'(exp_addr)) begin errors++; $display("FAIL after_frame_addr: got %0h expected %0h", mon_addr[n0], exp_addr); end
        end
        exp_addr++;
    endtask

    task automatic test_baud_clamp();
        int n0 = mon_dout.size();
        longint t0;
        baud_div = 16'd2;
        send_byte(8'hC3, 4, 1'b1, t0);
        repeat (10) @(negedge clk);
        checks++;
        if (mon_dout.size() != n0 + 1) begin
            errors++; $display("FAIL clamp_we: got %0d writes expected %0d", mon_dout.size(), n0 + 1);
        end else begin
            checks++; if (mon_dout[n0] !== 8'hC3) begin errors++; $display("FAIL clamp_dout: got %0h expected c3", mon_dout[n0]); end
            checks++; if (mon_addr[n0] !== ADDR_W'(exp_addr)) begin errors++; $display("FAIL clamp_addr: got %0h expected %0h", mon_addr[n0], exp_addr); end
        end
        exp_addr++;
        checks++; if (uart_mem_addr !== ADDR_W'(exp_addr)) begin errors++; $display("FAIL clamp_addr_after: got %0h expected %0h", uart_mem_addr, exp_addr); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single_byte();
        test_mid_reset();
        test_back_to_back();
        test_timeout();
        test_frame();
        test_baud_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
